// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file port arbiter: FSM state encoding
// and the default address/data widths and UART guard length.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UART_OWN = 2'd1,
        INT_OWN  = 2'd2
    } arb_state_t;

    localparam int RF_ADDR_W    = 8;
    localparam int RF_DATA_W    = 8;
    localparam int RF_GUARD_CYC = 4;

    // Preemption counter width and its saturation point
    localparam int PREEMPT_W = 8;
    localparam logic [PREEMPT_W-1:0] PREEMPT_MAX = '1;

endpackage

// File: rtl/regfile_arbiter.sv
// Arbiter for the single register-file port. The UART host path cannot stall,
// so whenever one of its strobes is high it owns the port combinationally.
// The internal master is served through a req/gnt handshake only after the
// UART has been quiet for a guard window, and is retried automatically when
// the UART steals the port from it.
module regfile_arbiter
    import rf_arb_pkg::*;
#(
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int DATA_W    = RF_DATA_W,
    parameter int GUARD_CYC = RF_GUARD_CYC
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 uart_write,
    input  logic [ADDR_W-1:0]    uart_write_addr,
    input  logic [DATA_W-1:0]    uart_write_data,
    input  logic                 uart_read,
    input  logic [ADDR_W-1:0]    uart_read_addr,
    output logic [DATA_W-1:0]    uart_read_data,
    input  logic                 int_req,
    input  logic                 int_wr,
    input  logic [ADDR_W-1:0]    int_addr,
    input  logic [DATA_W-1:0]    int_wdata,
    output logic                 int_gnt,
    output logic [DATA_W-1:0]    int_rdata,
    output logic                 int_rvalid,
    output logic [PREEMPT_W-1:0] preempt_cnt,
    output logic                 rf_write,
    output logic [ADDR_W-1:0]    rf_write_addr,
    output logic [DATA_W-1:0]    rf_write_data,
    output logic                 rf_read,
    output logic [ADDR_W-1:0]    rf_read_addr,
    input  logic [DATA_W-1:0]    rf_read_data
);

    // A zero-length guard still needs a 1-bit counter
    localparam int GUARD_W = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);
    localparam logic [GUARD_W-1:0] GUARD_RELOAD = GUARD_W'(GUARD_CYC);

    arb_state_t         state;
    logic [GUARD_W-1:0] guard_cnt;
    logic               uart_act;

    assign uart_act       = uart_write | uart_read;
    assign uart_read_data = rf_read_data;

    // Port mux: UART first (write beats read), then an internal op in INT_OWN, else idle zeros
    always_comb begin
        rf_write      = 1'b0;
        rf_write_addr = '0;
        rf_write_data = '0;
        rf_read       = 1'b0;
        rf_read_addr  = '0;
        int_gnt       = 1'b0;
        if (uart_write) begin
            rf_write      = 1'b1;
            rf_write_addr = uart_write_addr;
            rf_write_data = uart_write_data;
        end else if (uart_read) begin
            rf_read      = 1'b1;
            rf_read_addr = uart_read_addr;
        end else if (state == INT_OWN) begin
            int_gnt = 1'b1;
            if (int_wr) begin
                rf_write      = 1'b1;
                rf_write_addr = int_addr;
                rf_write_data = int_wdata;
            end else begin
                rf_read      = 1'b1;
                rf_read_addr = int_addr;
            end
        end
    end

    // Ownership FSM with inline guard timer, preemption counter and read-data capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            guard_cnt   <= '0;
            preempt_cnt <= '0;
            int_rdata   <= '0;
            int_rvalid  <= 1'b0;
        end else begin
            int_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (uart_act) begin
                        state     <= UART_OWN;
                        guard_cnt <= GUARD_RELOAD;
                    end else if (int_req) begin
                        state <= INT_OWN;
                    end
                end
                UART_OWN: begin
                    if (uart_act) begin
                        guard_cnt <= GUARD_RELOAD;
                    end else if (guard_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
                INT_OWN: begin
                    if (uart_act) begin
                        // Request stays pending at the master; it is reissued after the guard
                        state     <= UART_OWN;
                        guard_cnt <= GUARD_RELOAD;
                        if (preempt_cnt != PREEMPT_MAX) begin
                            preempt_cnt <= preempt_cnt + 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        if (!int_wr) begin
                            int_rdata  <= rf_read_data;
                            int_rvalid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: a table of UART-only vectors for the
// combinational port mux, then hand-written sequences for internal grants,
// guard timing, preemption, reset abort and counter saturation.
module tb_regfile_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int GUARD = 4;

    logic          clk;
    logic          reset_n;
    logic          uart_write;
    logic [AW-1:0] uart_write_addr;
    logic [DW-1:0] uart_write_data;
    logic          uart_read;
    logic [AW-1:0] uart_read_addr;
    logic [DW-1:0] uart_read_data;
    logic          int_req;
    logic          int_wr;
    logic [AW-1:0] int_addr;
    logic [DW-1:0] int_wdata;
    logic          int_gnt;
    logic [DW-1:0] int_rdata;
    logic          int_rvalid;
    logic [7:0]    preempt_cnt;
    logic          rf_write;
    logic [AW-1:0] rf_write_addr;
    logic [DW-1:0] rf_write_data;
    logic          rf_read;
    logic [AW-1:0] rf_read_addr;
    logic [DW-1:0] rf_read_data;

    int compCount = 0;
    int failCount = 0;

    regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW), .GUARD_CYC(GUARD)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .uart_write      (uart_write),
        .uart_write_addr (uart_write_addr),
        .uart_write_data (uart_write_data),
        .uart_read       (uart_read),
        .uart_read_addr  (uart_read_addr),
        .uart_read_data  (uart_read_data),
        .int_req         (int_req),
        .int_wr          (int_wr),
        .int_addr        (int_addr),
        .int_wdata       (int_wdata),
        .int_gnt         (int_gnt),
        .int_rdata       (int_rdata),
        .int_rvalid      (int_rvalid),
        .preempt_cnt     (preempt_cnt),
        .rf_write        (rf_write),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .rf_read         (rf_read),
        .rf_read_addr    (rf_read_addr),
        .rf_read_data    (rf_read_data)
    );

    // 100 MHz-style clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: synchronous write, zero-latency read
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (rf_write) mem[rf_write_addr] <= rf_write_data;
    end
    assign rf_read_data = mem[rf_read_addr];

    // Both UART strobes together is an illegal host condition
    always @(negedge clk) begin
        if (reset_n) assert (!(uart_write && uart_read)) else $error("[TB] both UART strobes high");
    end

    // Hard stop if the sequence ever wedges
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic          uw;
        logic          ur;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic          eRfw;
        logic          eRfr;
        logic [AW-1:0] eWa;
        logic [DW-1:0] eWd;
        logic [AW-1:0] eRa;
        logic          chkRd;
        logic [DW-1:0] eRd;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        nextCycle();
        uart_write      = v.uw;
        uart_read       = v.ur;
        uart_write_addr = v.wa;
        uart_write_data = v.wd;
        uart_read_addr  = v.ra;
    endtask

    // Single internal read from IDLE with UART quiet: gnt one cycle later, rvalid the cycle after
    task automatic intRead(input logic [AW-1:0] addr, input logic [DW-1:0] expData, input string tag);
        nextCycle();
        int_req = 1'b1; int_wr = 1'b0; int_addr = addr;
        @(negedge clk);
        checkOutput({tag, " gnt at req"}, int_gnt, 0);
        nextCycle();
        @(negedge clk);
        checkOutput({tag, " gnt"}, int_gnt, 1);
        checkOutput({tag, " rf_read"}, rf_read, 1);
        checkOutput({tag, " rf_write"}, rf_write, 0);
        checkOutput({tag, " rf_read_addr"}, rf_read_addr, addr);
        nextCycle();
        int_req = 1'b0;
        @(negedge clk);
        checkOutput({tag, " rvalid"}, int_rvalid, 1);
        checkOutput({tag, " rdata"}, int_rdata, expData);
        checkOutput({tag, " gnt drop"}, int_gnt, 0);
        nextCycle();
        @(negedge clk);
        checkOutput({tag, " rvalid pulse"}, int_rvalid, 0);
    endtask

    // Counts cycles (0 = current cycle) until int_gnt, leaving time at that cycle's negedge
    task automatic waitGrant(input int limit, output int delay);
        delay = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (int_gnt) begin
                delay = k;
                break;
            end
            nextCycle();
        end
    endtask

    initial begin
        int delay;
        int gntSeen;
        int expCnt;

        reset_n = 1'b0;
        uart_write = 1'b0; uart_read = 1'b0;
        uart_write_addr = '0; uart_write_data = '0; uart_read_addr = '0;
        int_req = 1'b0; int_wr = 1'b0; int_addr = '0; int_wdata = '0;

        // UART-only vectors: outputs follow the strobes in the same cycle
        vecs[0] = '{1'b1, 1'b0, 8'h05, 8'h77, 8'h00, 1'b1, 1'b0, 8'h05, 8'h77, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h22, 8'h3C, 8'h00, 1'b1, 1'b0, 8'h22, 8'h3C, 8'h00, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h05, 1'b0, 1'b1, 8'h00, 8'h00, 8'h05, 1'b1, 8'h77};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h22, 1'b0, 1'b1, 8'h00, 8'h00, 8'h22, 1'b1, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 8'h99, 8'h11, 8'h22, 1'b0, 1'b1, 8'h00, 8'h00, 8'h22, 1'b1, 8'h3C};

        // Reset state
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("reset int_gnt", int_gnt, 0);
        checkOutput("reset int_rvalid", int_rvalid, 0);
        checkOutput("reset int_rdata", int_rdata, 0);
        checkOutput("reset preempt_cnt", preempt_cnt, 0);
        checkOutput("reset rf_write", rf_write, 0);
        checkOutput("reset rf_read", rf_read, 0);
        nextCycle();
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d rf_write", i), rf_write, vecs[i].eRfw);
            checkOutput($sformatf("vec%0d rf_read", i), rf_read, vecs[i].eRfr);
            checkOutput($sformatf("vec%0d rf_write_addr", i), rf_write_addr, vecs[i].eWa);
            checkOutput($sformatf("vec%0d rf_write_data", i), rf_write_data, vecs[i].eWd);
            checkOutput($sformatf("vec%0d rf_read_addr", i), rf_read_addr, vecs[i].eRa);
            checkOutput($sformatf("vec%0d int_gnt", i), int_gnt, 0);
            if (vecs[i].chkRd) checkOutput($sformatf("vec%0d uart_read_data", i), uart_read_data, vecs[i].eRd);
        end
        uart_read = 1'b0;
        repeat (8) nextCycle();

        // Internal write with UART quiet: grant one cycle after the request
        int_req = 1'b1; int_wr = 1'b1; int_addr = 8'h10; int_wdata = 8'hA5;
        @(negedge clk);
        checkOutput("iwr gnt at req", int_gnt, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("iwr gnt", int_gnt, 1);
        checkOutput("iwr rf_write", rf_write, 1);
        checkOutput("iwr rf_read", rf_read, 0);
        checkOutput("iwr rf_write_addr", rf_write_addr, 8'h10);
        checkOutput("iwr rf_write_data", rf_write_data, 8'hA5);
        nextCycle();
        int_req = 1'b0;
        @(negedge clk);
        checkOutput("iwr gnt drop", int_gnt, 0);
        checkOutput("iwr rf_write drop", rf_write, 0);
        checkOutput("iwr rvalid", int_rvalid, 0);

        // Internal reads, including read-back of the internal write
        intRead(8'h22, 8'h3C, "ird22");
        intRead(8'h10, 8'hA5, "ird10");

        // UART write held 2 clks while an internal write is pending
        nextCycle();
        int_req = 1'b1; int_wr = 1'b1; int_addr = 8'h30; int_wdata = 8'h99;
        uart_write = 1'b1; uart_write_addr = 8'h05; uart_write_data = 8'h77;
        @(negedge clk);
        checkOutput("uw0 rf_write_addr", rf_write_addr, 8'h05);
        checkOutput("uw0 rf_write_data", rf_write_data, 8'h77);
        checkOutput("uw0 gnt", int_gnt, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("uw1 rf_write_addr", rf_write_addr, 8'h05);
        checkOutput("uw1 gnt", int_gnt, 0);
        nextCycle();
        uart_write = 1'b0;
        // Quiet cycles 0..3 count the guard 4->0, 4 returns to IDLE, 5 enters INT_OWN, 6 grants
        waitGrant(20, delay);
        checkOutput("guard grant delay", delay, GUARD + 2);
        checkOutput("guard rf_write_addr", rf_write_addr, 8'h30);
        checkOutput("guard rf_write_data", rf_write_data, 8'h99);
        nextCycle();
        int_req = 1'b0;
        @(negedge clk);
        checkOutput("guard gnt drop", int_gnt, 0);
        repeat (2) nextCycle();

        // Preemption: UART read arrives the cycle the internal read would be issued
        int_req = 1'b1; int_wr = 1'b0; int_addr = 8'h05;
        @(negedge clk);
        checkOutput("pre gnt at req", int_gnt, 0);
        nextCycle();
        uart_read = 1'b1; uart_read_addr = 8'h22;
        @(negedge clk);
        checkOutput("pre gnt", int_gnt, 0);
        checkOutput("pre rf_read", rf_read, 1);
        checkOutput("pre rf_read_addr", rf_read_addr, 8'h22);
        checkOutput("pre uart_read_data", uart_read_data, 8'h3C);
        nextCycle();
        @(negedge clk);
        checkOutput("pre preempt_cnt", preempt_cnt, 1);
        checkOutput("pre gnt hold1", int_gnt, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("pre gnt hold2", int_gnt, 0);
        nextCycle();
        uart_read = 1'b0;
        waitGrant(20, delay);
        checkOutput("pre retry delay", delay, GUARD + 2);
        checkOutput("pre retry rf_read_addr", rf_read_addr, 8'h05);
        nextCycle();
        int_req = 1'b0;
        @(negedge clk);
        checkOutput("pre retry rvalid", int_rvalid, 1);
        checkOutput("pre retry rdata", int_rdata, 8'h77);
        checkOutput("pre cnt stable", preempt_cnt, 1);
        repeat (2) nextCycle();

        // Reset pulse while INT_OWN
        int_req = 1'b1; int_wr = 1'b1; int_addr = 8'h40; int_wdata = 8'h11;
        nextCycle();
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("rstI gnt", int_gnt, 0);
        checkOutput("rstI rf_write", rf_write, 0);
        checkOutput("rstI rf_read", rf_read, 0);
        checkOutput("rstI preempt_cnt", preempt_cnt, 0);
        checkOutput("rstI rdata", int_rdata, 0);
        checkOutput("rstI rvalid", int_rvalid, 0);
        nextCycle();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rstI gnt at release", int_gnt, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("rstI regrant", int_gnt, 1);
        checkOutput("rstI regrant addr", rf_write_addr, 8'h40);
        nextCycle();
        int_req = 1'b0;
        repeat (2) nextCycle();

        // Reset pulse while UART_OWN: without the abort the grant would wait for the guard
        uart_write = 1'b1; uart_write_addr = 8'h41; uart_write_data = 8'h22;
        int_req = 1'b1; int_wr = 1'b1; int_addr = 8'h42; int_wdata = 8'h33;
        nextCycle();
        uart_write = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("rstU gnt", int_gnt, 0);
        checkOutput("rstU rf_write", rf_write, 0);
        checkOutput("rstU rf_write_addr", rf_write_addr, 0);
        checkOutput("rstU preempt_cnt", preempt_cnt, 0);
        nextCycle();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rstU gnt at release", int_gnt, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("rstU regrant", int_gnt, 1);
        checkOutput("rstU regrant data", rf_write_data, 8'h33);
        nextCycle();
        int_req = 1'b0;
        repeat (2) nextCycle();

        // 300 preemptions with int_req held: INT_OWN recurs every 7 cycles (1 busy + 6 quiet)
        int_req = 1'b1; int_wr = 1'b0; int_addr = 8'h05;
        gntSeen = 0;
        for (int i = 0; i < 300; i++) begin
            nextCycle();
            uart_read = 1'b1; uart_read_addr = 8'h22;
            @(negedge clk);
            if (int_gnt) gntSeen++;
            nextCycle();
            uart_read = 1'b0;
            for (int q = 0; q < 5; q++) begin
                @(negedge clk);
                if (int_gnt) gntSeen++;
                nextCycle();
            end
            @(negedge clk);
            if (int_gnt) gntSeen++;
            if (i == 0 || i == 99 || i == 254 || i == 255 || i == 299) begin
                expCnt = (i + 1 > 255) ? 255 : i + 1;
                checkOutput($sformatf("sat preempt_cnt after %0d", i + 1), preempt_cnt, expCnt);
            end
        end
        checkOutput("sat no grant", gntSeen, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("sat final grant", int_gnt, 1);
        nextCycle();
        int_req = 1'b0;
        @(negedge clk);
        checkOutput("sat final rvalid", int_rvalid, 1);
        checkOutput("sat final rdata", int_rdata, 8'h77);
        checkOutput("sat cnt held", preempt_cnt, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
